// File: rtl/car_ctrl_pkg.sv
// Shared move codes, key bit positions and decode helpers for the car motion path.
package car_ctrl_pkg;

    typedef enum logic [3:0] {
        MV_FWD  = 4'd0,
        MV_WA   = 4'd1,
        MV_WD   = 4'd2,
        MV_S    = 4'd3,
        MV_A    = 4'd4,
        MV_D    = 4'd5,
        MV_AS   = 4'd6,
        MV_DS   = 4'd7,
        MV_STOP = 4'd8
    } move_cmd_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_e;

    localparam int KEY_W    = 0;
    localparam int KEY_S    = 1;
    localparam int KEY_A    = 2;
    localparam int KEY_D    = 3;
    localparam int KEY_WA   = 4;
    localparam int KEY_WD   = 5;
    localparam int KEY_AS   = 6;
    localparam int KEY_DS   = 7;
    localparam int KEY_STOP = 8;

    localparam logic [3:0] STOP_CODE = 4'd8;

    function automatic move_cmd_e decode_auto(input logic [3:0] code);
        return (code > STOP_CODE) ? MV_STOP : move_cmd_e'(code);
    endfunction

    // Diagonals outrank the plain directions so a chorded press is not split.
    function automatic move_cmd_e key_to_cmd(input logic [8:0] keys);
        if (keys[KEY_STOP])    return MV_STOP;
        else if (keys[KEY_WA]) return MV_WA;
        else if (keys[KEY_WD]) return MV_WD;
        else if (keys[KEY_AS]) return MV_AS;
        else if (keys[KEY_DS]) return MV_DS;
        else if (keys[KEY_W])  return MV_FWD;
        else if (keys[KEY_S])  return MV_S;
        else if (keys[KEY_A])  return MV_A;
        else if (keys[KEY_D])  return MV_D;
        else                   return MV_STOP;
    endfunction

endpackage

// File: rtl/speed_ramp.sv
// Speed ramp: free-running step divider and a current speed that walks one level
// per step toward the target, with an immediate clear for emergency stops.
module speed_ramp
    import car_ctrl_pkg::*;
#(
    parameter int SPEED_W  = 4,
    parameter int RAMP_DIV = 2_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [SPEED_W-1:0] target,
    output logic [SPEED_W-1:0] cur_speed
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RAMP_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            cur_speed <= '0;
        end else begin
            div_cnt <= tick ? DIV_RELOAD : div_cnt - 1'b1;
            if (clear) begin
                cur_speed <= '0;
            end else if (tick) begin
                if (cur_speed < target)
                    cur_speed <= cur_speed + 1'b1;
                else if (cur_speed > target)
                    cur_speed <= cur_speed - 1'b1;
            end
        end
    end

endmodule

// File: rtl/motion_cmd_sequencer.sv
// Arbitrates manual keys vs autonomous commands, ramps speed, guards the auto link
// with a watchdog and hands {move_cmd, speed_level} frames to uart_comm.
//  state   | meaning
//  TX_IDLE | no frame outstanding; launch on first frame, change or refresh timeout
//  TX_PEND | frame presented with valid=1, waiting for ready
module motion_cmd_sequencer
    import car_ctrl_pkg::*;
#(
    parameter int SPEED_W        = 4,
    parameter int MAX_SPEED      = 15,
    parameter int RAMP_DIV       = 2_500_000,
    parameter int WDOG_CYCLES    = 25_000_000,
    parameter int REFRESH_CYCLES = 5_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               manual_on,
    input  logic               auto_on,
    input  logic [8:0]         keys,
    input  logic [SPEED_W-1:0] manual_speed,
    input  logic [3:0]         auto_cmd,
    input  logic [SPEED_W-1:0] auto_speed,
    input  logic               auto_valid,
    output logic [3:0]         move_cmd,
    output logic [SPEED_W-1:0] speed_level,
    output logic               valid,
    input  logic               ready,
    output logic               wdog_trip
);

    localparam int WD_W  = $clog2(WDOG_CYCLES + 1);
    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(WDOG_CYCLES - 1);
    localparam logic [REF_W-1:0]   REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [SPEED_W-1:0] MAX_LVL  = SPEED_W'(MAX_SPEED);

    logic               manual_mode, auto_mode;
    move_cmd_e          auto_cmd_r;
    logic [SPEED_W-1:0] auto_speed_r;
    logic [WD_W-1:0]    wdog_cnt;

    move_cmd_e          req_cmd;
    logic [SPEED_W-1:0] req_speed;
    move_cmd_e          cur_cmd;
    logic [SPEED_W-1:0] cur_speed;
    logic               ramp_clear, cmd_load;
    logic [SPEED_W-1:0] ramp_target;

    tx_state_e          tx_state, tx_state_nxt;
    move_cmd_e          pay_cmd, pay_cmd_nxt, last_cmd, last_cmd_nxt;
    logic [SPEED_W-1:0] pay_speed, pay_speed_nxt, last_speed, last_speed_nxt;
    logic               valid_nxt, sent_ok, sent_ok_nxt;
    logic [REF_W-1:0]   refresh_cnt, refresh_nxt;

    assign manual_mode = manual_on && !auto_on;
    assign auto_mode   = auto_on && !manual_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cmd_r   <= MV_STOP;
            auto_speed_r <= '0;
        end else if (auto_valid) begin
            auto_cmd_r   <= decode_auto(auto_cmd);
            auto_speed_r <= auto_speed;
        end
    end

    // A strobe in the same cycle as expiry wins, so the trip never asserts then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else if (!auto_mode || auto_valid) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else if (wdog_cnt == WD_LAST) begin
            wdog_trip <= 1'b1;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    always_comb begin
        req_cmd   = MV_STOP;
        req_speed = '0;
        if (manual_mode) begin
            req_cmd   = key_to_cmd(keys);
            req_speed = manual_speed;
        end else if (auto_mode && !wdog_trip) begin
            req_cmd   = auto_cmd_r;
            req_speed = auto_speed_r;
        end
    end

    // Direction only changes once the car is at standstill.
    always_comb begin
        ramp_clear  = (req_cmd == MV_STOP);
        ramp_target = '0;
        cmd_load    = 1'b0;
        if (!ramp_clear) begin
            if (req_cmd != cur_cmd)
                cmd_load = (cur_speed == '0);
            else
                ramp_target = (req_speed > MAX_LVL) ? MAX_LVL : req_speed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur_cmd <= MV_STOP;
        else if (ramp_clear)
            cur_cmd <= MV_STOP;
        else if (cmd_load)
            cur_cmd <= req_cmd;
    end

    speed_ramp #(
        .SPEED_W  (SPEED_W),
        .RAMP_DIV (RAMP_DIV)
    ) u_speed_ramp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ramp_clear),
        .target    (ramp_target),
        .cur_speed (cur_speed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            valid       <= 1'b0;
            pay_cmd     <= MV_STOP;
            pay_speed   <= '0;
            last_cmd    <= MV_STOP;
            last_speed  <= '0;
            sent_ok     <= 1'b0;
            refresh_cnt <= '0;
        end else begin
            tx_state    <= tx_state_nxt;
            valid       <= valid_nxt;
            pay_cmd     <= pay_cmd_nxt;
            pay_speed   <= pay_speed_nxt;
            last_cmd    <= last_cmd_nxt;
            last_speed  <= last_speed_nxt;
            sent_ok     <= sent_ok_nxt;
            refresh_cnt <= refresh_nxt;
        end
    end

    always_comb begin
        tx_state_nxt   = tx_state;
        valid_nxt      = valid;
        pay_cmd_nxt    = pay_cmd;
        pay_speed_nxt  = pay_speed;
        last_cmd_nxt   = last_cmd;
        last_speed_nxt = last_speed;
        sent_ok_nxt    = sent_ok;
        refresh_nxt    = (refresh_cnt >= REF_LAST) ? refresh_cnt : refresh_cnt + 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!sent_ok || cur_cmd != last_cmd || cur_speed != last_speed
                    || refresh_cnt >= REF_LAST) begin
                    pay_cmd_nxt   = cur_cmd;
                    pay_speed_nxt = cur_speed;
                    valid_nxt     = 1'b1;
                    tx_state_nxt  = TX_PEND;
                end
            end
            TX_PEND: begin
                if (ready) begin
                    valid_nxt      = 1'b0;
                    last_cmd_nxt   = pay_cmd;
                    last_speed_nxt = pay_speed;
                    sent_ok_nxt    = 1'b1;
                    refresh_nxt    = '0;
                    tx_state_nxt   = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    assign move_cmd    = pay_cmd;
    assign speed_level = pay_speed;

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// Randomized and directed bench for motion_cmd_sequencer against a cycle-level behavioural model.
module tb_motion_cmd_sequencer;

    localparam int SPEED_W        = 4;
    localparam int MAX_SPEED      = 12;
    localparam int RAMP_DIV       = 4;
    localparam int WDOG_CYCLES    = 20;
    localparam int REFRESH_CYCLES = 50;

    logic               clk;
    logic               rst_n;
    logic               manual_on, auto_on, auto_valid, ready;
    logic [8:0]         keys;
    logic [SPEED_W-1:0] manual_speed, auto_speed;
    logic [3:0]         auto_cmd;
    logic [3:0]         move_cmd;
    logic [SPEED_W-1:0] speed_level;
    logic               valid, wdog_trip;

    motion_cmd_sequencer #(
        .SPEED_W        (SPEED_W),
        .MAX_SPEED      (MAX_SPEED),
        .RAMP_DIV       (RAMP_DIV),
        .WDOG_CYCLES    (WDOG_CYCLES),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .manual_on    (manual_on),
        .auto_on      (auto_on),
        .keys         (keys),
        .manual_speed (manual_speed),
        .auto_cmd     (auto_cmd),
        .auto_speed   (auto_speed),
        .auto_valid   (auto_valid),
        .move_cmd     (move_cmd),
        .speed_level  (speed_level),
        .valid        (valid),
        .ready        (ready),
        .wdog_trip    (wdog_trip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Key priority listed by name order stop>wa>wd>as>ds>w>s>a>d as (bit, code) pairs.
    function automatic int key_code(input logic [8:0] k);
        int bit_of[9]  = '{8, 4, 5, 6, 7, 0, 1, 2, 3};
        int code_of[9] = '{8, 1, 2, 6, 7, 0, 3, 4, 5};
        for (int i = 0; i < 9; i++)
            if (k[bit_of[i]]) return code_of[i];
        return 8;
    endfunction

    // Reference model: plain integers, advanced once per rising edge from pre-edge values.
    int m_cmd, m_spd, m_pend, m_pay_cmd, m_pay_spd, m_last_cmd, m_last_spd;
    int m_sent_ok, m_since, m_quiet, m_trip, m_acmd, m_aspd, m_edges;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmd = 8; m_spd = 0; m_pend = 0; m_pay_cmd = 8; m_pay_spd = 0;
            m_last_cmd = 8; m_last_spd = 0; m_sent_ok = 0; m_since = 0;
            m_quiet = 0; m_trip = 0; m_acmd = 8; m_aspd = 0; m_edges = 0;
        end else begin
            int am, mm, rc, rs, tgt;
            bit tick;
            am = (auto_on && !manual_on) ? 1 : 0;
            mm = (manual_on && !auto_on) ? 1 : 0;
            if (mm != 0) begin
                rc = key_code(keys); rs = int'(manual_speed);
            end else if (am != 0 && m_trip == 0) begin
                rc = m_acmd; rs = m_aspd;
            end else begin
                rc = 8; rs = 0;
            end
            tick = (m_edges % RAMP_DIV) == 0;
            m_edges++;

            if (m_pend == 0) begin
                if (m_sent_ok == 0 || m_cmd != m_last_cmd || m_spd != m_last_spd
                    || m_since >= REFRESH_CYCLES - 1) begin
                    m_pend = 1; m_pay_cmd = m_cmd; m_pay_spd = m_spd;
                end
                m_since = (m_since + 1 > REFRESH_CYCLES - 1) ? REFRESH_CYCLES - 1 : m_since + 1;
            end else if (ready) begin
                m_pend = 0; m_last_cmd = m_pay_cmd; m_last_spd = m_pay_spd;
                m_sent_ok = 1; m_since = 0;
            end else begin
                m_since = (m_since + 1 > REFRESH_CYCLES - 1) ? REFRESH_CYCLES - 1 : m_since + 1;
            end

            if (rc == 8) begin
                m_cmd = 8; m_spd = 0;
            end else if (rc != m_cmd) begin
                if (m_spd == 0) m_cmd = rc;
                else if (tick) m_spd = m_spd - 1;
            end else begin
                tgt = (rs > MAX_SPEED) ? MAX_SPEED : rs;
                if (tick && tgt > m_spd) m_spd = m_spd + 1;
                else if (tick && tgt < m_spd) m_spd = m_spd - 1;
            end

            if (am == 0 || auto_valid) m_quiet = 0;
            else if (m_quiet < WDOG_CYCLES) m_quiet++;
            m_trip = (m_quiet >= WDOG_CYCLES) ? 1 : 0;

            if (auto_valid) begin
                m_acmd = (int'(auto_cmd) > 8) ? 8 : int'(auto_cmd);
                m_aspd = int'(auto_speed);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid",       32'(valid),       32'(m_pend));
            check("move_cmd",    32'(move_cmd),    32'(m_pay_cmd));
            check("speed_level", 32'(speed_level), 32'(m_pay_spd));
            check("wdog_trip",   32'(wdog_trip),   32'(m_trip));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_manual(input logic [8:0] k, input int spd);
        manual_on = 1'b1; auto_on = 1'b0; keys = k; manual_speed = SPEED_W'(spd);
    endtask

    initial begin
        rst_n = 1'b0; manual_on = 1'b0; auto_on = 1'b0; keys = '0;
        manual_speed = '0; auto_cmd = '0; auto_speed = '0; auto_valid = 1'b0; ready = 1'b1;
        cyc(3);
        check("rst_valid", 32'(valid),       32'd0);
        check("rst_cmd",   32'(move_cmd),    32'd8);
        check("rst_speed", 32'(speed_level), 32'd0);
        check("rst_trip",  32'(wdog_trip),   32'd0);
        rst_n = 1'b1;

        cyc(1);
        check("first_frame_valid", 32'(valid), 32'd1);
        cyc(110);

        set_manual(9'b0_0000_0001, 3);
        cyc(30);
        set_manual(9'b0_0000_0010, 3);
        cyc(40);
        set_manual(9'b0_0000_0001, 3);
        cyc(30);
        keys = 9'b1_0000_0001;
        cyc(10);
        set_manual(9'b0_0000_0001, 15);
        cyc(70);

        manual_on = 1'b0; auto_on = 1'b1;
        auto_cmd = 4'd4; auto_speed = 4'd2; auto_valid = 1'b1;
        cyc(1);
        auto_valid = 1'b0;
        cyc(19);
        check("wdog_before_limit", 32'(wdog_trip), 32'd0);
        cyc(1);
        check("wdog_at_limit", 32'(wdog_trip), 32'd1);
        cyc(10);
        auto_cmd = 4'd11; auto_valid = 1'b1;
        cyc(1);
        auto_valid = 1'b0;
        cyc(1);
        check("wdog_cleared", 32'(wdog_trip), 32'd0);
        cyc(10);

        set_manual(9'b0_0000_0001, 5);
        cyc(30);
        ready = 1'b0;
        cyc(1);
        keys = 9'b0_0000_0100;
        cyc(10);
        ready = 1'b1;
        cyc(40);

        for (int seg = 0; seg < 300; seg++) begin
            int mode, len, vprob, rprob;
            mode = $urandom_range(0, 9);
            manual_on = (mode < 5 || mode == 9);
            auto_on   = (mode >= 5);
            case ($urandom_range(0, 3))
                0:       keys = '0;
                1:       keys = 9'(1 << $urandom_range(0, 8));
                default: keys = 9'($urandom_range(0, 511));
            endcase
            manual_speed = SPEED_W'($urandom_range(0, 15));
            vprob = $urandom_range(0, 2);
            rprob = $urandom_range(0, 1);
            len = $urandom_range(1, 40);
            if (seg == 150) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            for (int c = 0; c < len; c++) begin
                auto_valid = (vprob == 0) ? 1'b0 :
                             (vprob == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
                auto_cmd   = 4'($urandom_range(0, 15));
                auto_speed = SPEED_W'($urandom_range(0, 15));
                ready      = (rprob == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                cyc(1);
            end
        end

        auto_valid = 1'b0; ready = 1'b1;
        cyc(5);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
